food_placer: RTL

Consumes the free-running random coordinates from the random XY generator and turns them into a legal food position for the snake game. On a placement request it samples `randomX`/`randomY`, snaps them to the play grid and rejects off-screen values. It then checks each candidate against the snake body through an occupancy handshake, and retries until it finds a free cell. It sits between the random XY generator and the game-logic/render stages, which read `food_x`/`food_y`.

---
 rtl/snake_pkg.sv | 20 ++
 rtl/food_placer_if.sv | 21 ++
 rtl/food_grid_snap.sv | 46 ++++
 rtl/food_placer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game constants and the food placer state type.
// Screen is 240x320 pixels on an 8-pixel grid.
package snake_pkg;

    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 9;
    localparam int unsigned GRID_SHIFT = 3;

    localparam logic [X_W-1:0] SCREEN_W = 8'd240;
    localparam logic [Y_W-1:0] SCREEN_H = 9'd320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_QUERY,
        ST_PLACE
    } food_state_t;

endpackage

// File: rtl/food_placer_if.sv
// Occupancy query handshake between the food placer (master) and the
// snake-body lookup (slave); occ_hit is valid in the occ_ack cycle.
interface food_placer_if;

    logic                          occ_req;
    logic [snake_pkg::X_W-1:0]     occ_x;
    logic [snake_pkg::Y_W-1:0]     occ_y;
    logic                          occ_ack;
    logic                          occ_hit;

    modport master (
        output occ_req, occ_x, occ_y,
        input  occ_ack, occ_hit
    );

    modport slave (
        input  occ_req, occ_x, occ_y,
        output occ_ack, occ_hit
    );

endinterface

// File: rtl/food_grid_snap.sv
// Registers a grid-snapped candidate from the random XY inputs together
// with its on-screen flag, so the checking state sees a stable sample.
module food_grid_snap
    import snake_pkg::*;
#(
    parameter int unsigned SHIFT = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           i_sample,
    input  logic [X_W-1:0] i_rand_x,
    input  logic [Y_W-1:0] i_rand_y,
    output logic [X_W-1:0] o_cx,
    output logic [Y_W-1:0] o_cy,
    output logic           o_in_bounds
);

    localparam logic [X_W-1:0] X_MASK = {X_W{1'b1}} << SHIFT;
    localparam logic [Y_W-1:0] Y_MASK = {Y_W{1'b1}} << SHIFT;

    logic [X_W-1:0] w_cx;
    logic [Y_W-1:0] w_cy;
    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;
    logic           r_in_bounds;

    assign w_cx = i_rand_x & X_MASK;
    assign w_cy = i_rand_y & Y_MASK;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cx        <= '0;
            r_cy        <= '0;
            r_in_bounds <= 1'b0;
        end else if (i_sample) begin
            r_cx        <= w_cx;
            r_cy        <= w_cy;
            r_in_bounds <= (w_cx < SCREEN_W) && (w_cy < SCREEN_H);
        end
    end

    assign o_cx        = r_cx;
    assign o_cy        = r_cy;
    assign o_in_bounds = r_in_bounds;

endmodule

// File: rtl/food_placer.sv
// Picks a free, on-screen, grid-aligned food cell by sampling random XY and
// querying snake occupancy. FOOD_RETRY_LIMIT_EN bounds the search by MAX_TRIES.
module food_placer
    import snake_pkg::*;
#(
    parameter int unsigned    GRID_SHIFT = snake_pkg::GRID_SHIFT,
    parameter logic [X_W-1:0] INIT_X     = 8'd120,
    parameter logic [Y_W-1:0] INIT_Y     = 9'd160,
    parameter int unsigned    MAX_TRIES  = 15
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [X_W-1:0] randomX,
    input  logic [Y_W-1:0] randomY,
    input  logic           place_req,
    food_placer_if.master  occ,
    output logic [X_W-1:0] food_x,
    output logic [Y_W-1:0] food_y,
    output logic           food_valid,
    output logic           busy,
    output logic           place_done,
    output logic           place_fail
);

    food_state_t    r_state;
    logic [X_W-1:0] r_food_x;
    logic [Y_W-1:0] r_food_y;
    logic           r_food_valid;
    logic           r_busy;
    logic           r_done;
    logic           r_occ_req;
    logic [X_W-1:0] r_occ_x;
    logic [Y_W-1:0] r_occ_y;
    logic [3:0]     r_tries;

    logic           w_sample;
    logic [X_W-1:0] w_cx;
    logic [Y_W-1:0] w_cy;
    logic           w_in_bounds;
    logic           w_reject;
    logic [3:0]     w_tries_next;

    assign w_sample = (r_state == ST_SAMPLE);

    food_grid_snap #(
        .SHIFT (GRID_SHIFT)
    ) u_snap (
        .clock       (clock),
        .reset       (reset),
        .i_sample    (w_sample),
        .i_rand_x    (randomX),
        .i_rand_y    (randomY),
        .o_cx        (w_cx),
        .o_cy        (w_cy),
        .o_in_bounds (w_in_bounds)
    );

    // A rejected candidate either fell off-screen or landed on the snake.
    assign w_reject = ((r_state == ST_CHECK) && !w_in_bounds) ||
                      ((r_state == ST_QUERY) && occ.occ_ack && occ.occ_hit);
    assign w_tries_next = (r_tries == 4'hF) ? r_tries : r_tries + 4'd1;

`ifdef FOOD_RETRY_LIMIT_EN
    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);
    logic r_fail;
    logic w_limit_hit;
    assign w_limit_hit = (w_tries_next >= TRY_LIMIT);
    assign place_fail  = r_fail;
`else
    logic w_unused_limit;
    assign w_unused_limit = ^MAX_TRIES;
    assign place_fail     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_food_x     <= INIT_X;
            r_food_y     <= INIT_Y;
            r_food_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_occ_req    <= 1'b0;
            r_occ_x      <= '0;
            r_occ_y      <= '0;
            r_tries      <= '0;
`ifdef FOOD_RETRY_LIMIT_EN
            r_fail       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef FOOD_RETRY_LIMIT_EN
            r_fail <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (place_req) begin
                        r_food_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_tries      <= '0;
                        r_state      <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: r_state <= ST_CHECK;
                ST_CHECK: begin
                    if (w_in_bounds) begin
                        r_occ_req <= 1'b1;
                        r_occ_x   <= w_cx;
                        r_occ_y   <= w_cy;
                        r_state   <= ST_QUERY;
                    end
                end
                ST_QUERY: begin
                    if (occ.occ_ack) begin
                        r_occ_req <= 1'b0;
                        if (!occ.occ_hit) begin
                            r_food_x     <= r_occ_x;
                            r_food_y     <= r_occ_y;
                            r_food_valid <= 1'b1;
                            r_done       <= 1'b1;
                            r_state      <= ST_PLACE;
                        end
                    end
                end
                ST_PLACE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Rejection handling overrides the per-state next state above.
            if (w_reject) begin
`ifdef FOOD_RETRY_LIMIT_EN
                if (w_limit_hit) begin
                    r_fail       <= 1'b1;
                    r_food_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end else begin
                    r_tries <= w_tries_next;
                    r_state <= ST_SAMPLE;
                end
`else
                r_tries <= w_tries_next;
                r_state <= ST_SAMPLE;
`endif
            end
        end
    end

    assign occ.occ_req = r_occ_req;
    assign occ.occ_x   = r_occ_x;
    assign occ.occ_y   = r_occ_y;
    assign food_x      = r_food_x;
    assign food_y      = r_food_y;
    assign food_valid  = r_food_valid;
    assign busy        = r_busy;
    assign place_done  = r_done;

endmodule
